// File: rtl/uart_pkg.sv
// Shared definitions for the icestick UART transmit path: arbiter states,
// frame geometry and the default bit period.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_HOLD = 2'd2
  } arb_state_e;

  localparam int FRAME_BITS       = 10;
  localparam int DEFAULT_BAUD_DIV = 1250;  // 12 MHz / 9600

  // Line level for bit position idx of an 8N1 frame (0 = start, 9 = stop).
  function automatic logic frame_bit(input logic [7:0] d, input logic [3:0] idx);
    if (idx == 4'd0) return 1'b0;
    if (idx >= 4'd9) return 1'b1;
    return d[3'(idx - 4'd1)];
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: a start pulse loads a byte, the frame begins the next cycle
// and done strobes during the final stop-bit cycle.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(FRAME_BITS - 1);

  logic          active_q, active_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          bit_end;

  assign bit_end = (baud_q == BAUD_LAST);
  assign done    = active_q && bit_end && (bit_q == BIT_LAST);
  // Idle-high whenever no frame is active, including straight out of reset.
  assign tx      = active_q ? frame_bit(data_q, bit_q) : 1'b1;

  always_comb begin
    active_d = active_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    data_d   = data_q;
    if (start) begin
      active_d = 1'b1;
      baud_d   = '0;
      bit_d    = '0;
      data_d   = data;
    end else if (active_q) begin
      if (bit_end) begin
        baud_d = '0;
        if (bit_q == BIT_LAST) active_d = 1'b0;
        else                   bit_d    = bit_q + 4'd1;
      end else begin
        baud_d = baud_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      data_q   <= '0;
    end else begin
      active_q <= active_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 transmitter among NREQ byte streams,
// with an owner lock that keeps the line for multi-byte messages.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [8*NREQ-1:0]        req_data,
  input  logic [NREQ-1:0]          req_lock,
  output logic [NREQ-1:0]          req_ready,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  grant_id
);

  localparam int IDW = $clog2(NREQ);

  arb_state_e           state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       grant_q, grant_d;
  logic [IDW-1:0]       win_idx, sel;
  logic                 win_found, accept, ser_done;
  logic [NREQ-1:0][7:0] data_pk;

  assign data_pk  = req_data;
  assign busy     = (state_q != ST_IDLE);
  assign grant_id = grant_q;

  // First valid requester scanning upward from the round-robin pointer.
  always_comb begin
    int idx;
    logic [IDW-1:0] cand;
    idx       = 0;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IDW'(idx);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    req_ready = '0;
    accept    = 1'b0;
    sel       = grant_q;
    case (state_q)
      ST_IDLE: begin
        accept = win_found;
        sel    = win_idx;
      end
      ST_SEND: begin
        if (ser_done) state_d = req_lock[grant_q] ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        if (req_valid[grant_q])     accept  = 1'b1;
        else if (!req_lock[grant_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // The strobe is an output of a reset block, so it is masked while reset is held.
    accept = accept && resetn;
    if (accept) begin
      req_ready[sel] = 1'b1;
      grant_d        = sel;
      ptr_d          = (sel == IDW'(NREQ - 1)) ? '0 : sel + 1'b1;
      state_d        = ST_SEND;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  uart_tx_serializer #(.BAUD_DIV(BAUD_DIV)) u_ser (
    .clk    (clk),
    .resetn (resetn),
    .start  (accept),
    .data   (data_pk[sel]),
    .tx     (tx),
    .done   (ser_done)
  );

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one 8N1 UART transmitter between NREQ byte-stream requesters on the icestick design (echo path, status reporter, LED-state reporter).
- Round-robin arbitration per byte, with an optional per-requester lock that holds the line for multi-byte messages.
- Owns the serializer and drives the TX pin directly.

Parameters:
- NREQ, 4, number of requesters (2..8)
- BAUD_DIV, 1250, clk cycles per bit (12 MHz / 9600)

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  NREQ  requester i has a byte pending
- req_data  in  8*NREQ  byte for requester i at bits [8i+7:8i]
- req_lock  in  NREQ  requester i keeps ownership after its current byte
- req_ready  out  NREQ  one-hot, single-cycle accept strobe
- tx  out  1  UART line, idle high
- busy  out  1  frame in progress or line held by a lock
- grant_id  out  $clog2(NREQ)  index of the current or last owner

Behaviour:
- Reset values:
  - tx=1, req_ready=0, busy=0, grant_id=0.
  - Round-robin pointer set so requester 0 has top priority.
  - Reset is asynchronous: mid-frame reset forces tx=1 immediately and drops the frame.
- States: IDLE, SEND, HOLD.
- IDLE:
  - If any req_valid, choose the first valid index scanning from (grant_id+1) mod NREQ.
  - After reset, the scan starts at 0.
  - Same cycle: req_ready[winner]=1, latch req_data[winner] and grant_id=winner, go to SEND.
  - Nothing valid: remain in IDLE, busy=0.
- SEND:
  - The start bit begins the cycle after acceptance.
  - Frame: 0, d[0]..d[7], 1. Each bit lasts exactly BAUD_DIV cycles, so a frame is 10*BAUD_DIV cycles.
  - busy=1 throughout.
  - req_valid/req_data changes have no effect on the frame in flight.
  - On the last stop-bit cycle, sample req_lock[grant_id]: 1 -> HOLD, 0 -> IDLE.
- HOLD:
  - Only the owner is eligible; busy=1, tx=1.
  - If req_valid[owner]: accept as in IDLE (ready strobe, same grant_id), go to SEND.
  - Else if req_lock[owner]=0: go to IDLE with no strobe.
  - Other requesters wait indefinitely while the lock is held.
- Gap timing: back-to-back bytes (from IDLE or HOLD) have exactly 1 idle-high cycle between the stop bit and the next start bit.
- Handshake: a byte is transferred only in the cycle req_ready[i]=1. Requesters must hold valid/data stable until that cycle. req_ready is never asserted for an index whose req_valid is low.
- Counters:
  - Baud counter width $clog2(BAUD_DIV); counts 0..BAUD_DIV-1 and wraps at the bit boundary.
  - Bit index counts 0..9.
  - Both counters clear on acceptance.

Decomposition:
- Shared package (uart_pkg):
  - state encoding constants (IDLE/SEND/HOLD)
  - FRAME_BITS=10
  - default BAUD_DIV for 12 MHz/9600
- One sub-module, uart_tx_serializer (clk, resetn, start, data[7:0] -> tx, done):
  - done pulses on the last stop-bit cycle.
  - The arbiter holds state, the round-robin pointer and the lock logic.

Test Plan (BAUD_DIV=4 unless noted):
- Reset and idle: resetn low mid-frame -> tx=1 the same cycle, busy=0, req_ready=0. With all req_valid=0 for 100 cycles after release, tx stays 1.
- Single byte: req0 sends 0x31 -> req_ready[0] for one cycle. tx reads 0,1,0,0,0,1,1,0,0,1, each bit 4 cycles (40 cycles total), busy=1 throughout. tx is then 1 and busy=0.
- Round robin: req0..3 all valid with 0x31..0x34, no locks -> grant order 0,1,2,3. Frames are 41 cycles apart (40 + 1 gap). Requester 0 re-raises after its first byte -> it is served after 3, not before 1.
- Lock:
  - req1 sends 0x41,0x42,0x43 with lock high while req0 is also valid -> all three req1 bytes go out consecutively before req0.
  - Lock drops while req1 valid is low in HOLD -> IDLE, then req0 is granted.
- HOLD wait: owner keeps lock=1, valid=0 for 200 cycles -> tx=1, busy=1, no req_ready to others. Owner later raises valid with 0x55 -> accepted with no other grant in between.
- Full-rate timing (BAUD_DIV=1250): req2 sends 0x35 -> frame lasts 12500 cycles. A testbench UART receiver sampling mid-bit recovers 0x35 and grant_id=2.
